// File: rtl/aes_pkg.sv
// aes_pkg: AES byte-stream tables, key schedule and FSM states shared by the cipher and the decipher.
package aes_pkg;
    localparam logic [7:0] RCON = 8'h1B;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic {IDLE, ACTIVE} state_t;

    function automatic logic [7:0] key_next(input logic [7:0] k);
        return {k[6:0], k[7]} ^ RCON;
    endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box lookup.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] cipher_byte,
    output logic [7:0] sub_byte
);
    assign sub_byte = INV_SBOX[cipher_byte];
endmodule

// File: rtl/aes_decipher.sv
// aes_decipher: byte-serial AES stream decipher, P_i = INV_SBOX(C_i) ^ K_i, two-stage pipeline.
module aes_decipher
    import aes_pkg::*;
#(
    parameter int MSG_BYTES = 16
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_in,
    input  logic       new_message,
    input  logic [7:0] key,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       last_out,
    output logic       drop_err
);
    localparam int CNT_W = $clog2(MSG_BYTES + 1);

    state_t           state, state_nx;
    logic [7:0]       key_reg, key_reg_nx, k_cur, inv_byte, s1_byte, s1_key;
    logic [CNT_W-1:0] count, count_nx, count_inc;
    logic             accept, last, s1_valid, s1_last;

    aes_inv_sbox u_inv_sbox (.cipher_byte(data_in), .sub_byte(inv_byte));

    // new_message overrides the stored schedule so a same-cycle byte uses key as K_0
    always_comb begin
        accept     = valid_in && (new_message || state == ACTIVE);
        k_cur      = new_message ? key : key_reg;
        count_inc  = (new_message ? '0 : count) + CNT_W'(1);
        last       = accept && count_inc == CNT_W'(MSG_BYTES);
        state_nx   = last ? IDLE : new_message ? ACTIVE : state;
        key_reg_nx = accept ? key_next(k_cur) : new_message ? key : key_reg;
        count_nx   = accept ? count_inc : new_message ? '0 : count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            key_reg   <= '0;
            count     <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_byte   <= '0;
            s1_key    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            key_reg   <= key_reg_nx;
            count     <= count_nx;
            s1_valid  <= accept;
            s1_last   <= last;
            s1_byte   <= inv_byte;
            s1_key    <= k_cur;
            drop_err  <= valid_in && !accept;
            valid_out <= s1_valid;
            last_out  <= s1_valid && s1_last;
            if (s1_valid) data_out <= s1_byte ^ s1_key;
        end
    end
endmodule

// File: tb/tb_aes_decipher.sv
// tb_aes_decipher: randomized self-checking bench against a message-level reference model.
module tb_aes_decipher;
    localparam int N = 3;
    localparam int T = 48;
    localparam int MB [N] = '{16, 4, 1};

    typedef struct {bit nm; logic [7:0] k; bit v; logic [7:0] d;} stim_t;

    logic clk = 0, reset_n = 0, valid_in = 0, new_message = 0;
    logic [7:0] key = 0, data_in = 0;
    logic [7:0] d_o [N];
    logic v_o [N], l_o [N], e_o [N];

    int cmps = 0, errs = 0, cyc = 0, base = 0;
    bit rec = 0;
    stim_t st[$];
    logic [7:0] sbox_t [256], inv_t [256];
    bit ov [N][T], ol [N][T], oe [N][T], xv [N][T], xl [N][T], xe [N][T];
    logic [7:0] od [N][T], xd [N][T];

    aes_decipher #(.MSG_BYTES(16)) dut0 (.clk(clk), .reset_n(reset_n), .valid_in(valid_in), .new_message(new_message),
        .key(key), .data_in(data_in), .data_out(d_o[0]), .valid_out(v_o[0]), .last_out(l_o[0]), .drop_err(e_o[0]));
    aes_decipher #(.MSG_BYTES(4)) dut1 (.clk(clk), .reset_n(reset_n), .valid_in(valid_in), .new_message(new_message),
        .key(key), .data_in(data_in), .data_out(d_o[1]), .valid_out(v_o[1]), .last_out(l_o[1]), .drop_err(e_o[1]));
    aes_decipher #(.MSG_BYTES(1)) dut2 (.clk(clk), .reset_n(reset_n), .valid_in(valid_in), .new_message(new_message),
        .key(key), .data_in(data_in), .data_out(d_o[2]), .valid_out(v_o[2]), .last_out(l_o[2]), .drop_err(e_o[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rec && cyc - base < T) begin
            for (int j = 0; j < N; j++) begin
                ov[j][cyc-base] = v_o[j]; ol[j][cyc-base] = l_o[j];
                oe[j][cyc-base] = e_o[j]; od[j][cyc-base] = d_o[j];
            end
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    function automatic void build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = 0;
            for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            sbox_t[x] = y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
            inv_t[sbox_t[x]] = 8'(x);
        end
    endfunction

    function automatic logic [7:0] ks(input logic [7:0] k);
        int r = ((int'(k) * 2) % 256) + int'(k) / 128;
        return 8'(r) ^ 8'h1b;
    endfunction

    // Message-level model: per instance, which cycle carries which plaintext/last/drop
    function automatic void model();
        for (int j = 0; j < N; j++) begin
            bit active = 0;
            logic [7:0] k = 0;
            int n = 0;
            for (int t = 0; t < T; t++) begin xv[j][t] = 0; xl[j][t] = 0; xe[j][t] = 0; xd[j][t] = 0; end
            foreach (st[i]) begin
                if (st[i].nm) begin active = 1; k = st[i].k; n = 0; end
                if (st[i].v && active) begin
                    n++;
                    xv[j][i+2] = 1; xd[j][i+2] = inv_t[st[i].d] ^ k; xl[j][i+2] = (n == MB[j]);
                    k = ks(k);
                    if (n == MB[j]) active = 0;
                end else if (st[i].v) xe[j][i+1] = 1;
            end
        end
    endfunction

    task automatic do_reset();
        reset_n = 0; new_message = 0; valid_in = 0; key = 0; data_in = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic apply();
        for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin ov[j][t] = 0; ol[j][t] = 0; oe[j][t] = 0; od[j][t] = 0; end
        @(posedge clk); #1;
        base = cyc; rec = 1;
        foreach (st[i]) begin
            new_message = st[i].nm; key = st[i].k; valid_in = st[i].v; data_in = st[i].d;
            @(posedge clk); #1;
        end
        new_message = 0; valid_in = 0;
        repeat (4) @(posedge clk);
        @(negedge clk); rec = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; new_message = 0; valid_in = 0;
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            cmps++;
            if ({v_o[j], l_o[j], e_o[j], d_o[j]} !== 11'h000) begin
                errs++; $display("FAIL reset dut%0d: v/l/e/d=%b/%b/%b/%h want 0/0/0/00", j, v_o[j], l_o[j], e_o[j], d_o[j]);
            end
        end
        @(posedge clk); #1 reset_n = 1;
    endtask

    task automatic test_basic();
        do_reset(); st = {};
        st.push_back('{1'b1, 8'h11, 1'b0, 8'h00}); st.push_back('{1'b0, 8'h00, 1'b1, 8'h82});
        apply(); model();
        cmps++;
        if (!ov[0][3] || od[0][3] !== 8'h00) begin errs++; $display("FAIL basic: v=%b d=%h want 1/00", ov[0][3], od[0][3]); end
        for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin
            cmps++;
            if (ov[j][t] !== xv[j][t] || oe[j][t] !== xe[j][t] || (xv[j][t] && {ol[j][t], od[j][t]} !== {xl[j][t], xd[j][t]})) begin
                errs++; $display("FAIL basic dut%0d c%0d: v/l/d/e=%b/%b/%h/%b want %b/%b/%h/%b", j, t, ov[j][t], ol[j][t], od[j][t], oe[j][t], xv[j][t], xl[j][t], xd[j][t], xe[j][t]);
            end
        end
    endtask

    task automatic test_schedule();
        do_reset(); st = {};
        st.push_back('{1'b1, 8'h11, 1'b0, 8'h00}); st.push_back('{1'b0, 8'h00, 1'b1, 8'h82});
        st.push_back('{1'b0, 8'h00, 1'b1, 8'h63});
        apply(); model();
        cmps++;
        if (!ov[0][3] || !ov[0][4] || od[0][3] !== 8'h00 || od[0][4] !== 8'h39) begin
            errs++; $display("FAIL schedule: d=%h,%h want 00,39", od[0][3], od[0][4]);
        end
        for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin
            cmps++;
            if (ov[j][t] !== xv[j][t] || oe[j][t] !== xe[j][t] || (xv[j][t] && {ol[j][t], od[j][t]} !== {xl[j][t], xd[j][t]})) begin
                errs++; $display("FAIL schedule dut%0d c%0d: v/l/d/e=%b/%b/%h/%b want %b/%b/%h/%b", j, t, ov[j][t], ol[j][t], od[j][t], oe[j][t], xv[j][t], xl[j][t], xd[j][t], xe[j][t]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] p [10];
        logic [7:0] k = 8'h11;
        int pulses = 0;
        do_reset(); st = {};
        st.push_back('{1'b1, 8'h11, 1'b0, 8'h00});
        for (int i = 0; i < 10; i++) begin
            p[i] = 8'($urandom);
            st.push_back('{1'b0, 8'h00, 1'b1, sbox_t[p[i] ^ k]});
            k = ks(k);
        end
        apply();
        for (int i = 0; i < 10; i++) begin
            cmps++;
            if (!ov[0][i+3] || od[0][i+3] !== p[i]) begin
                errs++; $display("FAIL round_trip byte%0d: v=%b d=%h want 1/%h", i, ov[0][i+3], od[0][i+3], p[i]);
            end
        end
        for (int t = 0; t < T; t++) pulses += int'(ov[0][t]);
        cmps++;
        if (pulses != 10) begin errs++; $display("FAIL round_trip pulses: %0d want 10", pulses); end
    endtask

    task automatic test_msg_end();
        int pulses = 0;
        do_reset(); st = {};
        st.push_back('{1'b1, 8'($urandom), 1'b0, 8'h00});
        for (int i = 0; i < 5; i++) st.push_back('{1'b0, 8'h00, 1'b1, 8'($urandom)});
        apply(); model();
        for (int t = 0; t < T; t++) pulses += int'(ov[1][t]);
        cmps++;
        if (pulses != 4 || !ol[1][6] || !oe[1][6] || ov[1][7]) begin
            errs++; $display("FAIL msg_end: pulses=%0d last4=%b drop=%b v5=%b want 4/1/1/0", pulses, ol[1][6], oe[1][6], ov[1][7]);
        end
        for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin
            cmps++;
            if (ov[j][t] !== xv[j][t] || oe[j][t] !== xe[j][t] || (xv[j][t] && {ol[j][t], od[j][t]} !== {xl[j][t], xd[j][t]})) begin
                errs++; $display("FAIL msg_end dut%0d c%0d: v/l/d/e=%b/%b/%h/%b want %b/%b/%h/%b", j, t, ov[j][t], ol[j][t], od[j][t], oe[j][t], xv[j][t], xl[j][t], xd[j][t], xe[j][t]);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset(); st = {};
        st.push_back('{1'b1, 8'h11, 1'b1, 8'h82}); st.push_back('{1'b0, 8'h00, 1'b1, 8'h63});
        apply();
        cmps++;
        if (!ov[0][2] || !ov[0][3] || od[0][2] !== 8'h00 || od[0][3] !== 8'h39) begin
            errs++; $display("FAIL same_cycle: v=%b%b d=%h,%h want 11 00,39", ov[0][2], ov[0][3], od[0][2], od[0][3]);
        end
        cmps++;
        if (!ol[2][2] || !oe[2][2] || ov[2][3]) begin
            errs++; $display("FAIL same_cycle single: last=%b drop=%b v=%b want 1/1/0", ol[2][2], oe[2][2], ov[2][3]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset(); st = {};
            for (int i = 0; i < 30; i++)
                st.push_back('{(i == 0) || ($urandom_range(7) == 0), 8'($urandom), $urandom_range(3) != 0, 8'($urandom)});
            apply(); model();
            for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin
                cmps++;
                if (ov[j][t] !== xv[j][t] || oe[j][t] !== xe[j][t] || (xv[j][t] && {ol[j][t], od[j][t]} !== {xl[j][t], xd[j][t]})) begin
                    errs++; $display("FAIL random%0d dut%0d c%0d: v/l/d/e=%b/%b/%h/%b want %b/%b/%h/%b", r, j, t, ov[j][t], ol[j][t], od[j][t], oe[j][t], xv[j][t], xl[j][t], xd[j][t], xe[j][t]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1 new_message = 1; key = 8'h11; valid_in = 1; data_in = 8'h82;
        @(posedge clk); #1 new_message = 0; data_in = 8'h63;
        @(posedge clk); #1 valid_in = 0; reset_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin @(posedge clk); #1 reset_n = 1; end
            #2;
            for (int j = 0; j < N; j++) begin
                cmps++;
                if (v_o[j] !== 1'b0 || d_o[j] !== 8'h00) begin
                    errs++; $display("FAIL reset_mid dut%0d step%0d: v=%b d=%h want 0/00", j, c, v_o[j], d_o[j]);
                end
            end
            @(negedge clk);
        end
        st = {};
        st.push_back('{1'b0, 8'h00, 1'b1, 8'($urandom)});
        apply(); model();
        for (int j = 0; j < N; j++) for (int t = 0; t < T; t++) begin
            cmps++;
            if (ov[j][t] !== xv[j][t] || oe[j][t] !== xe[j][t]) begin
                errs++; $display("FAIL reset_mid drop dut%0d c%0d: v/e=%b/%b want %b/%b", j, t, ov[j][t], oe[j][t], xv[j][t], xe[j][t]);
            end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_basic();
        test_schedule();
        test_round_trip();
        test_msg_end();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
